// File: rtl/lsu_bridge_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lsu_bridge_if                                                   |
// | Purpose  : Bundles the CPU-side request/response handshake and the        |
// |            memory-side word bus of the load/store bridge.                  |
// | Modports : slave  - the bridge's view (drives req_ready, resp_*, stall,    |
// |                     mem_addr/wdata/be, mem_read_en/mem_write_en)           |
// |            master - the environment's view (drives req_*, mem_busy,        |
// |                     mem_read_avail, mem_rdata)                             |
// | Signals  : req_valid/req_ready/req_we/req_addr/req_wdata/req_size/         |
// |            req_unsigned, resp_valid/resp_rdata/resp_err, stall,            |
// |            mem_addr (word address), mem_wdata, mem_be, mem_write_en,       |
// |            mem_read_en, mem_busy, mem_read_avail, mem_rdata                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface lsu_bridge_if #(
  parameter int CPU_W  = 32,
  parameter int MEM_W  = 16,
  parameter int ADDR_W = 23
);
  localparam int OFF_W = $clog2(MEM_W / 8);

  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  logic [ADDR_W-1:0]         req_addr;
  logic [CPU_W-1:0]          req_wdata;
  logic [1:0]                req_size;
  logic                      req_unsigned;

  logic                      resp_valid;
  logic [CPU_W-1:0]          resp_rdata;
  logic                      resp_err;
  logic                      stall;

  logic [ADDR_W-OFF_W-1:0]   mem_addr;
  logic [MEM_W-1:0]          mem_wdata;
  logic [MEM_W/8-1:0]        mem_be;
  logic                      mem_write_en;
  logic                      mem_read_en;
  logic                      mem_busy;
  logic                      mem_read_avail;
  logic [MEM_W-1:0]          mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    input  mem_busy, mem_read_avail, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall,
    output mem_addr, mem_wdata, mem_be, mem_write_en, mem_read_en
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    output mem_busy, mem_read_avail, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall,
    input  mem_addr, mem_wdata, mem_be, mem_write_en, mem_read_en
  );
endinterface
`default_nettype wire

// File: rtl/lsu_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lsu_bridge                                                      |
// | Purpose  : Converts one CPU load/store (byte..dword) into one or more      |
// |            narrower memory word beats, with alignment checking, lane      |
// |            replication for narrow stores, load extraction/extension and   |
// |            a per-beat wait timeout.                                        |
// | Ports    : clk     - clock                                                 |
// |            reset_n - asynchronous active-low reset                         |
// |            bus     - lsu_bridge_if.slave (CPU request/response + memory)   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module lsu_bridge #(
  parameter int CPU_W   = 32,
  parameter int MEM_W   = 16,
  parameter int ADDR_W  = 23,
  parameter int TIMEOUT = 255
) (
  input wire logic    clk,
  input wire logic    reset_n,
  lsu_bridge_if.slave bus
);

  localparam int MEM_BYTES = MEM_W / 8;
  localparam int OFF_W     = $clog2(MEM_BYTES);
  localparam int WADDR_W   = ADDR_W - OFF_W;
  localparam int MAX_BEATS = CPU_W / MEM_W;
  localparam int BEAT_W    = $clog2(MAX_BEATS + 1);
  localparam int TMO_W     = $clog2(TIMEOUT + 1);
  localparam int DIDX_W    = $clog2(CPU_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state_q,  state_d;
  logic                we_q,     we_d;
  logic [ADDR_W-1:0]   addr_q,   addr_d;
  logic [CPU_W-1:0]    wdata_q,  wdata_d;
  logic [1:0]          size_q,   size_d;
  logic                uns_q,    uns_d;
  logic                err_q,    err_d;
  logic [BEAT_W-1:0]   beat_q,   beat_d;
  logic [BEAT_W-1:0]   nbeats_q, nbeats_d;
  logic [TMO_W-1:0]    tmo_q,    tmo_d;
  logic [CPU_W-1:0]    rbuf_q,   rbuf_d;

  // Request decode (valid in IDLE only)
  logic                w_misalign;
  int                  w_req_bits;
  // Beat completion in WAIT
  logic                w_beat_done;
  // Datapath helpers for the captured request
  int                  w_acc_bytes;
  int                  w_ld_bits;
  int                  w_off_bytes;
  logic                w_narrow;
  logic [CPU_W-1:0]    w_wshift;
  logic [MEM_W-1:0]    w_lanes;
  logic [MEM_BYTES-1:0] w_be;
  logic [CPU_W-1:0]    w_load_raw;
  logic [CPU_W-1:0]    w_load_mask;
  logic                w_load_sign;
  logic [CPU_W-1:0]    w_load_ext;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      err_q    <= 1'b0;
      beat_q   <= '0;
      nbeats_q <= '0;
      tmo_q    <= '0;
      rbuf_q   <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      err_q    <= err_d;
      beat_q   <= beat_d;
      nbeats_q <= nbeats_d;
      tmo_q    <= tmo_d;
      rbuf_q   <= rbuf_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    uns_d    = uns_q;
    err_d    = err_q;
    beat_d   = beat_q;
    nbeats_d = nbeats_q;
    tmo_d    = tmo_q;
    rbuf_d   = rbuf_q;

    // A dword on a 32-bit CPU has nowhere to go, so it is treated as misaligned.
    w_misalign = ((bus.req_addr & ADDR_W'((1 << bus.req_size) - 1)) != '0) ||
                 ((bus.req_size == 2'd3) && (CPU_W == 32));
    w_req_bits = 8 << bus.req_size;

    // Writes cannot complete on the first WAIT cycle: the memory needs one
    // cycle to raise mem_busy after accepting the write.
    w_beat_done = we_q ? (!bus.mem_busy && (tmo_q != '0)) : bus.mem_read_avail;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d     = bus.req_we;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          size_d   = bus.req_size;
          uns_d    = bus.req_unsigned;
          beat_d   = '0;
          tmo_d    = '0;
          rbuf_d   = '0;
          nbeats_d = (w_req_bits <= MEM_W) ? BEAT_W'(1) : BEAT_W'(w_req_bits / MEM_W);
          err_d    = w_misalign;
          state_d  = w_misalign ? RESP : ISSUE;
        end
      end

      ISSUE: begin
        tmo_d = '0;
        if (!bus.mem_busy) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (w_beat_done) begin
          if (!we_q) begin
            for (int k = 0; k < MAX_BEATS; k++) begin
              if (beat_q == BEAT_W'(k)) begin
                rbuf_d[k*MEM_W +: MEM_W] = bus.mem_rdata;
              end
            end
          end
          if (beat_q == nbeats_q - BEAT_W'(1)) begin
            state_d = RESP;
          end else begin
            beat_d  = beat_q + BEAT_W'(1);
            state_d = ISSUE;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: store lanes / byte enables and load extraction
  // --------------------------------------------------------------------------
  always_comb begin
    w_acc_bytes = 1 << size_q;
    w_ld_bits   = 8 << size_q;
    w_off_bytes = int'(addr_q & ADDR_W'(MEM_BYTES - 1));
    // Accesses narrower than a memory word occupy part of one word; wider
    // ones are size-aligned, so they start at lane 0 of each beat.
    w_narrow    = (w_acc_bytes < MEM_BYTES);

    w_wshift = wdata_q >> (int'(beat_q) * MEM_W);
    w_lanes  = w_wshift[MEM_W-1:0];
    w_be     = '1;
    if (w_narrow) begin
      for (int i = 0; i < MEM_BYTES; i++) begin
        unique case (size_q)
          2'd0:    w_lanes[i*8 +: 8] = wdata_q[7:0];
          2'd1:    w_lanes[i*8 +: 8] = wdata_q[(i % 2)*8 +: 8];
          default: w_lanes[i*8 +: 8] = wdata_q[(i % 4)*8 +: 8];
        endcase
      end
      w_be = MEM_BYTES'(((1 << w_acc_bytes) - 1) << w_off_bytes);
    end

    w_load_raw  = w_narrow ? (rbuf_q >> (w_off_bytes * 8)) : rbuf_q;
    w_load_mask = '1;
    w_load_sign = 1'b0;
    if (w_ld_bits < CPU_W) begin
      w_load_mask = {CPU_W{1'b1}} >> (CPU_W - w_ld_bits);
    end
    if (w_ld_bits <= CPU_W) begin
      w_load_sign = w_load_raw[DIDX_W'(w_ld_bits - 1)];
    end
    w_load_ext = (w_load_raw & w_load_mask) |
                 ((!uns_q && w_load_sign) ? ~w_load_mask : '0);
  end

  // --------------------------------------------------------------------------
  // Outputs (all zero while reset_n is low, since the state is forced IDLE
  // and the IDLE-dependent outputs are gated by reset_n)
  // --------------------------------------------------------------------------
  always_comb begin
    bus.req_ready    = reset_n && (state_q == IDLE);
    bus.stall        = reset_n && ((state_q == ISSUE) || (state_q == WAIT) ||
                                   ((state_q == IDLE) && bus.req_valid));
    bus.resp_valid   = (state_q == RESP);
    bus.resp_err     = (state_q == RESP) && err_q;
    bus.resp_rdata   = ((state_q == RESP) && !err_q && !we_q) ? w_load_ext : '0;

    bus.mem_read_en  = (state_q == ISSUE) && !bus.mem_busy && !we_q;
    bus.mem_write_en = (state_q == ISSUE) && !bus.mem_busy &&  we_q;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    bus.mem_be       = '0;
    if (state_q == ISSUE) begin
      bus.mem_addr  = addr_q[ADDR_W-1:OFF_W] + WADDR_W'(beat_q);
      bus.mem_wdata = w_lanes;
      bus.mem_be    = w_be;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_lsu_bridge                                                   |
// | Purpose  : Directed table-driven bench for lsu_bridge (CPU_W=32, MEM_W=16, |
// |            TIMEOUT=16) with a small word-memory responder, plus hand       |
// |            sequences for store lanes, timeout, busy and mid-beat reset.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_lsu_bridge;
  localparam int CPU_W   = 32;
  localparam int MEM_W   = 16;
  localparam int ADDR_W  = 23;
  localparam int TIMEOUT = 16;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  lsu_bridge_if #(.CPU_W(CPU_W), .MEM_W(MEM_W), .ADDR_W(ADDR_W)) bus ();

  lsu_bridge #(.CPU_W(CPU_W), .MEM_W(MEM_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- memory
  logic [15:0] mem [0:1023];
  int          rd_pulses  = 0;
  int          wr_pulses  = 0;
  logic [21:0] last_waddr = '0;
  logic [15:0] last_wdata = '0;
  logic [1:0]  last_wbe   = '0;
  bit          rd_mute    = 1'b0;
  int          rd_lat     = 0;
  bit          pend       = 1'b0;
  int          pend_cnt   = 0;
  logic [9:0]  pend_idx   = '0;

  // Samples enables mid-cycle, returns read data rd_lat cycles after the
  // first WAIT cycle as a one-cycle mem_read_avail pulse.
  always @(negedge clk) begin
    if (!reset_n) begin
      pend               = 1'b0;
      bus.mem_read_avail = 1'b0;
      bus.mem_rdata      = '0;
    end else begin
      bus.mem_read_avail = 1'b0;
      if (pend) begin
        if (rd_mute) begin
          pend = 1'b0;
        end else if (pend_cnt == 0) begin
          bus.mem_read_avail = 1'b1;
          bus.mem_rdata      = mem[pend_idx];
          pend               = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      if (bus.mem_read_en) begin
        rd_pulses++;
        pend     = 1'b1;
        pend_cnt = rd_lat;
        pend_idx = bus.mem_addr[9:0];
      end
      if (bus.mem_write_en) begin
        wr_pulses++;
        last_waddr = bus.mem_addr;
        last_wdata = bus.mem_wdata;
        last_wbe   = bus.mem_be;
        if (bus.mem_be[0]) mem[bus.mem_addr[9:0]][7:0]  = bus.mem_wdata[7:0];
        if (bus.mem_be[1]) mem[bus.mem_addr[9:0]][15:8] = bus.mem_wdata[15:8];
      end
    end
  end

  // ------------------------------------------------------------- requests
  // Called at posedge+1; returns at posedge+1 one cycle after the response.
  task automatic do_req(input logic we, input logic [22:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output logic st, output logic rdy_pre);
    rdy_pre          = bus.req_ready;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat   = 1;
    rdata = '0;
    err   = 1'b0;
    st    = 1'b1;
    while (!bus.resp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (bus.resp_valid) begin
      rdata = bus.resp_rdata;
      err   = bus.resp_err;
      st    = bus.stall;
    end else begin
      lat = -1;
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        we;
    logic [22:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  initial begin
    logic [31:0] rdata;
    logic        err, st, rdy;
    int          lat, r0, w0, n, seen;

    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.req_size     = '0;
    bus.req_unsigned = 1'b0;
    bus.mem_busy     = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[10'h080] = 16'hBEEF;
    mem[10'h081] = 16'hDEAD;
    mem[10'h100] = 16'h1234;
    mem[10'h102] = 16'h7700;

    //            we    addr       wdata          sz    uns   rdata          err  lat rd wr
    vecs[0]  = '{1'b0, 23'h100, 32'h0,        2'd2, 1'b0, 32'hDEADBEEF, 1'b0, 5, 2, 0};
    vecs[1]  = '{1'b1, 23'h100, 32'h000080F0, 2'd1, 1'b0, 32'h0,        1'b0, 4, 0, 1};
    vecs[2]  = '{1'b0, 23'h101, 32'h0,        2'd0, 1'b0, 32'hFFFFFF80, 1'b0, 3, 1, 0};
    vecs[3]  = '{1'b0, 23'h101, 32'h0,        2'd0, 1'b1, 32'h00000080, 1'b0, 3, 1, 0};
    vecs[4]  = '{1'b0, 23'h100, 32'h0,        2'd0, 1'b0, 32'hFFFFFFF0, 1'b0, 3, 1, 0};
    vecs[5]  = '{1'b0, 23'h100, 32'h0,        2'd1, 1'b0, 32'hFFFF80F0, 1'b0, 3, 1, 0};
    vecs[6]  = '{1'b0, 23'h100, 32'h0,        2'd1, 1'b1, 32'h000080F0, 1'b0, 3, 1, 0};
    vecs[7]  = '{1'b1, 23'h201, 32'h000000A5, 2'd0, 1'b0, 32'h0,        1'b0, 4, 0, 1};
    vecs[8]  = '{1'b0, 23'h200, 32'h0,        2'd1, 1'b1, 32'h0000A534, 1'b0, 3, 1, 0};
    vecs[9]  = '{1'b0, 23'h200, 32'h0,        2'd0, 1'b0, 32'h00000034, 1'b0, 3, 1, 0};
    vecs[10] = '{1'b1, 23'h300, 32'h89ABCDEF, 2'd2, 1'b0, 32'h0,        1'b0, 7, 0, 2};
    vecs[11] = '{1'b0, 23'h300, 32'h0,        2'd2, 1'b0, 32'h89ABCDEF, 1'b0, 5, 2, 0};
    vecs[12] = '{1'b0, 23'h302, 32'h0,        2'd1, 1'b0, 32'hFFFF89AB, 1'b0, 3, 1, 0};
    vecs[13] = '{1'b0, 23'h303, 32'h0,        2'd0, 1'b1, 32'h00000089, 1'b0, 3, 1, 0};
    vecs[14] = '{1'b1, 23'h103, 32'h00001234, 2'd1, 1'b0, 32'h0,        1'b1, 1, 0, 0};
    vecs[15] = '{1'b0, 23'h102, 32'h0,        2'd2, 1'b0, 32'h0,        1'b1, 1, 0, 0};
    vecs[16] = '{1'b0, 23'h000, 32'h0,        2'd3, 1'b0, 32'h0,        1'b1, 1, 0, 0};
    vecs[17] = '{1'b0, 23'h101, 32'h0,        2'd1, 1'b1, 32'h0,        1'b1, 1, 0, 0};
    vecs[18] = '{1'b1, 23'h204, 32'hFFFFFF5A, 2'd0, 1'b0, 32'h0,        1'b0, 4, 0, 1};
    vecs[19] = '{1'b0, 23'h204, 32'h0,        2'd1, 1'b1, 32'h0000775A, 1'b0, 3, 1, 0};

    // ---- reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", {bus.resp_valid, bus.resp_err, bus.mem_read_en, bus.mem_write_en, bus.stall}, 5'b0);
    check("rst_data", {bus.resp_rdata, bus.mem_addr, bus.mem_wdata, bus.mem_be}, '0);
    reset_n = 1'b1;
    #1;
    check("rst_release_ready", bus.req_ready, 1'b1);
    check("rst_release_stall", bus.stall, 1'b0);
    @(posedge clk); #1;

    // ---- table
    for (int i = 0; i < NVEC; i++) begin
      r0 = rd_pulses;
      w0 = wr_pulses;
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns,
             rdata, err, lat, st, rdy);
      check($sformatf("v%0d_ready", i), rdy, 1'b1);
      check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), err, vecs[i].exp_err);
      check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_rd_pulses", i), rd_pulses - r0, vecs[i].exp_rd);
      check($sformatf("v%0d_wr_pulses", i), wr_pulses - w0, vecs[i].exp_wr);
      check($sformatf("v%0d_stall_in_resp", i), st, 1'b0);
      check($sformatf("v%0d_resp_one_cycle", i), bus.resp_valid, 1'b0);
    end

    // ---- SB lane replication and byte enable
    w0 = wr_pulses;
    do_req(1'b1, 23'h201, 32'h000000A5, 2'd0, 1'b0, rdata, err, lat, st, rdy);
    check("sb_pulses", wr_pulses - w0, 1);
    check("sb_mem_addr", last_waddr, 22'h100);
    check("sb_mem_wdata", last_wdata, 16'hA5A5);
    check("sb_mem_be", last_wbe, 2'b10);

    // ---- timeout: LW 0x0 with no read data
    rd_mute = 1'b1;
    r0 = rd_pulses;
    do_req(1'b0, 23'h000, 32'h0, 2'd2, 1'b0, rdata, err, lat, st, rdy);
    check("tmo_err", err, 1'b1);
    check("tmo_rdata", rdata, 32'h0);
    check("tmo_lat", lat, 18);
    check("tmo_rd_pulses", rd_pulses - r0, 1);
    rd_mute = 1'b0;
    do_req(1'b0, 23'h300, 32'h0, 2'd2, 1'b0, rdata, err, lat, st, rdy);
    check("after_tmo_ready", rdy, 1'b1);
    check("after_tmo_rdata", rdata, 32'h89ABCDEF);
    check("after_tmo_err", err, 1'b0);

    // ---- mem_busy holds ISSUE
    r0 = rd_pulses;
    bus.mem_busy     = 1'b1;
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b0;
    bus.req_addr     = 23'h200;
    bus.req_size     = 2'd1;
    bus.req_unsigned = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("busy_no_read_en", bus.mem_read_en, 1'b0);
    check("busy_stall", bus.stall, 1'b1);
    @(posedge clk); #1;
    check("busy_no_pulse", rd_pulses - r0, 0);
    bus.mem_busy = 1'b0;
    n = 0;
    while (!bus.resp_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy_extra_cycles", n, 2);
    check("busy_rdata", bus.resp_rdata, 32'h0000A534);
    check("busy_rd_pulses", rd_pulses - r0, 1);
    @(posedge clk); #1;

    // ---- reset during WAIT of beat 1 of an LW
    rd_lat = 5;
    r0 = rd_pulses;
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b0;
    bus.req_addr     = 23'h100;
    bus.req_size     = 2'd2;
    bus.req_unsigned = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    while ((rd_pulses - r0) < 2 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_rst_second_beat", rd_pulses - r0, 2);
    check("mid_rst_in_wait_stall", bus.stall, 1'b1);
    #2;
    bus.req_valid = 1'b1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_ctrl", {bus.resp_valid, bus.resp_err, bus.mem_read_en, bus.mem_write_en,
                           bus.stall, bus.req_ready}, 6'b0);
    check("mid_rst_data", {bus.resp_rdata, bus.mem_addr, bus.mem_wdata, bus.mem_be}, '0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    reset_n = 1'b1;
    #1;
    check("mid_rst_ready", bus.req_ready, 1'b1);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (bus.resp_valid) seen++;
    end
    check("mid_rst_no_resp", seen, 0);
    rd_lat = 0;
    do_req(1'b0, 23'h100, 32'h0, 2'd2, 1'b0, rdata, err, lat, st, rdy);
    check("post_rst_rdata", rdata, 32'hDEAD80F0);
    check("post_rst_lat", lat, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/lsu_bridge.md
LSU_BRIDGE -- requirements
Module: lsu_bridge

Interface
REQ-001 SHALL have parameter CPU_W, default 32, meaning CPU data width; legal values 32, 64.
REQ-002 SHALL have parameter MEM_W, default 16, meaning memory word width; legal values 8, 16, 32, with MEM_W <= CPU_W.
REQ-003 SHALL have parameter ADDR_W, default 23, meaning byte address width.
REQ-004 SHALL have parameter TIMEOUT, default 255, meaning the maximum wait cycles per beat before abort.
REQ-005 SHALL have ports: clk  in  1  clock; reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: req_valid in 1; req_ready out 1; req_we in 1 (1=store); req_addr in ADDR_W (byte address); req_wdata in CPU_W; req_size in 2 (0 byte, 1 half, 2 word, 3 dword); req_unsigned in 1 (zero-extend loads).
REQ-007 SHALL have ports: resp_valid out 1; resp_rdata out CPU_W; resp_err out 1; stall out 1 (pipeline hold).
REQ-008 SHALL have ports: mem_addr out ADDR_W-log2(MEM_W/8) (word address); mem_wdata out MEM_W; mem_be out MEM_W/8; mem_write_en out 1; mem_read_en out 1; mem_busy in 1; mem_read_avail in 1; mem_rdata in MEM_W.

Function
REQ-009 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; req_ready=1 only in IDLE; a request is accepted on req_valid&req_ready.
REQ-010 SHALL flag a request as misaligned when req_addr is not a multiple of 2^req_size, or when req_size=3 with CPU_W=32; IDLE->RESP with resp_err=1, no memory enable asserted.
REQ-011 SHALL compute beats = max(1, 2^req_size*8/MEM_W); beat k addresses word (req_addr>>log2(MEM_W/8))+k, lowest address first (little-endian).
REQ-012 SHALL, in ISSUE, wait until mem_busy=0, then drive mem_read_en or mem_write_en high for exactly one cycle with mem_addr, mem_wdata and mem_be valid in that cycle, then move to WAIT.
REQ-013 SHALL complete a read beat on the first WAIT cycle with mem_read_avail=1, capturing mem_rdata into buffer bits [k*MEM_W +: MEM_W].
REQ-014 SHALL complete a write beat on the first WAIT cycle with mem_busy=0, excluding the first WAIT cycle.
REQ-015 SHALL go WAIT->ISSUE after a beat completes when beats remain, and WAIT->RESP after the last beat completes.
REQ-016 SHALL, for stores narrower than MEM_W, replicate the store data across all lanes and one-hot/contiguous mem_be by address offset; otherwise mem_be SHALL be all ones.
REQ-017 SHALL extract load data by address offset and size, and sign-extend it (req_unsigned=0) or zero-extend it (req_unsigned=1) to CPU_W; word loads with CPU_W=64 SHALL also extend.
REQ-018 SHALL count WAIT cycles per beat; when the count reaches TIMEOUT with the beat incomplete, the block SHALL abort to RESP with resp_err=1 and resp_rdata=0; the counter SHALL clear on every ISSUE.
REQ-019 SHALL assert resp_valid for exactly one cycle, in RESP, then return to IDLE; resp_rdata SHALL be 0 for stores and errors.
REQ-020 SHALL drive stall = (state in ISSUE or WAIT) or (state==IDLE and req_valid); stall SHALL be 0 in RESP.
REQ-021 SHALL ignore mem_read_avail outside WAIT and ignore req_valid outside IDLE.
REQ-022 SHALL give a minimum latency from acceptance to resp_valid of 2*beats+1 cycles, and 1 cycle for misaligned requests.

Reset
REQ-023 SHALL, while reset_n=0 (asynchronously, including mid-beat), force state IDLE, beat/timeout counters to 0, and req_ready=1 when reset_n=1 after reset.
REQ-024 SHALL, while reset_n=0, force resp_valid, resp_err, mem_read_en, mem_write_en and stall to 0, and resp_rdata, mem_addr, mem_wdata and mem_be to 0.

Verification (CPU_W=32, MEM_W=16, TIMEOUT=16)
REQ-025 SHALL cover LW: LW 0x100, mem returns 0xBEEF (word 0x80) then 0xDEAD (word 0x81) -> two read pulses, resp_rdata=0xDEADBEEF, resp_err=0.
REQ-026 SHALL cover byte loads: LB 0x101 with word 0x80 = 0x80F0 -> 0xFFFFFF80; the same as LBU -> 0x00000080.
REQ-027 SHALL cover SB: SB 0x201 data 0x000000A5 -> one write pulse, mem_addr=0x100, mem_wdata=0xA5A5, mem_be=2'b10.
REQ-028 SHALL cover misalignment: SH 0x103 -> resp_valid the next cycle, resp_err=1, no memory enable asserted.
REQ-029 SHALL cover timeout: LW 0x0 with mem_read_avail held 0 -> resp_err=1 and resp_rdata=0 after 16 WAIT cycles; the next request is accepted normally.
REQ-030 SHALL cover reset mid-operation: reset_n pulsed low during WAIT of beat 1 of an LW -> all outputs 0 immediately, IDLE and req_ready=1 after release, no resp_valid.
